// File: rtl/serial_addsub_pkg.sv
// -----------------------------------------------------------------------------
// serial_addsub_pkg
//   Definitions shared by the bit-serial add/subtract unit:
//     WIDTH_DEFAULT : default operand/result width (18 bits)
//     OP_ADD/OP_SUB : encodings of the op input (0 = a+b, 1 = a-b)
//     state_t       : controller states IDLE / RUN / DONE
//   Helper:
//     cnt_width()   : width of a counter that must be able to hold 0..n
// -----------------------------------------------------------------------------
package serial_addsub_pkg;

  localparam int WIDTH_DEFAULT = 18;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count from 0 up to and including n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_addsub_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   One-bit full-adder cell used as the arithmetic core of serial_addsub.
//   Ports:
//     a, b   : operand bits
//     c_in   : carry in
//     s      : sum bit       = a ^ b ^ c_in
//     c_out  : carry out     = majority(a, b, c_in)
// -----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  logic w_half;

  assign w_half = a ^ b;
  assign s      = w_half ^ c_in;
  assign c_out  = (a & b) | (c_in & w_half);

endmodule

// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//   Bit-serial two's-complement adder/subtractor. One operand pair is accepted
//   in IDLE, processed LSB first through a single full-adder cell over WIDTH
//   RUN cycles, and the result plus flags are presented in DONE until the
//   consumer accepts them. Subtraction is a + ~b + 1 (carry flop seeded with 1).
//
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : asynchronous active-low reset
//     in_valid  : operand set offered
//     in_ready  : block can accept operands (IDLE only)
//     a, b      : operands (WIDTH bits, two's complement)
//     op        : 0 = a+b, 1 = a-b
//     out_valid : result and flags valid (DONE only)
//     out_ready : consumer accepts the result
//     result    : sum/difference modulo 2^WIDTH
//     carry     : final carry out (NOT-borrow when subtracting)
//     zero      : result == 0
//     negative  : result MSB
//     overflow  : signed overflow
// -----------------------------------------------------------------------------
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;        // shifts right, r_a[0] feeds the cell
  logic [WIDTH-1:0] r_b;        // latched b, already inverted for subtract
  logic [WIDTH-1:0] r_result;   // sum bits enter at the MSB
  logic             r_c;        // running carry
  logic [CW-1:0]    r_cnt;      // bits processed so far
  logic             r_a_msb;    // operand sign bits kept for the overflow flag,
  logic             r_b_msb;    // since the shifters lose them during RUN

  logic             r_carry;
  logic             r_zero;
  logic             r_negative;
  logic             r_overflow;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic             w_take;         // operand handshake
  logic             w_last;         // final bit being processed this cycle
  logic [WIDTH-1:0] w_b_eff;        // b as it enters the adder path
  logic             w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_result_next;  // result register after this cycle's shift

  assign w_take  = in_valid & (r_state == IDLE);
  assign w_last  = (r_state == RUN) && (r_cnt == LAST_BIT);
  assign w_b_eff = (op == OP_SUB) ? ~b : b;

  full_adder u_fa (
    .a     (r_a[0]),
    .b     (r_b[0]),
    .c_in  (r_c),
    .s     (w_sum),
    .c_out (w_cout)
  );

  // Sum bit enters at the MSB; after WIDTH shifts the first (LSB) sum bit
  // has travelled down to bit 0.
  generate
    if (WIDTH > 1) begin : g_shift_wide
      assign w_result_next = {w_sum, r_result[WIDTH-1:1]};
    end else begin : g_shift_single
      assign w_result_next = w_sum;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (r_cnt == LAST_BIT) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand shifters, carry, counter and result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
    end else if (w_take) begin
      r_a     <= a;
      r_b     <= w_b_eff;
      r_c     <= op;              // +1 for two's-complement subtract
      r_cnt   <= '0;
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= w_b_eff[WIDTH-1];
    end else if (r_state == RUN) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_c      <= w_cout;
      r_result <= w_result_next;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Flags: captured only on the final RUN cycle so they stay stable in DONE
  // and across later IDLE periods.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry    <= 1'b0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_last) begin
      r_carry    <= w_cout;
      r_zero     <= (w_result_next == '0);
      r_negative <= w_sum;
      // Same-signed operands (after b inversion) producing a different sign.
      r_overflow <= (r_a_msb == r_b_msb) & (w_sum != r_a_msb);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign negative  = r_negative;
  assign overflow  = r_overflow;

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter WIDTH, default 18, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 in_valid  input  1  operand set offered.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  WIDTH  minuend / first addend, two's complement.
REQ-007 b  input  WIDTH  subtrahend / second addend, two's complement.
REQ-008 op  input  1  0 = a+b, 1 = a-b.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  sum/difference modulo 2^WIDTH.
REQ-012 carry  output  1  final carry-out; for op=1 this is NOT-borrow.
REQ-013 zero  output  1  result == 0.
REQ-014 negative  output  1  result[WIDTH-1].
REQ-015 overflow  output  1  signed overflow.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; a transfer occurs on an edge with in_valid & in_ready.
REQ-018 On transfer, the block SHALL latch a, b and op; preload the bit counter to 0; set the carry flop to op; invert latched b when op=1; then enter RUN.
REQ-019 Each RUN cycle SHALL process one bit, LSB first, through one full-adder cell: sum bit = a0 ^ b0' ^ c; carry updates to the cell's carry-out; a and b' shift right; the sum bit shifts into the result MSB.
REQ-020 After exactly WIDTH RUN cycles, the FSM SHALL enter DONE; a transfer at edge k SHALL give out_valid = 1 after edge k+WIDTH (18 cycles at default).
REQ-021 In DONE, out_valid SHALL be 1 and result and all flags SHALL hold stable until out_valid & out_ready.
- The FSM SHALL then return to IDLE on that edge.
- There SHALL be no overlap: a new transfer is possible at the earliest one cycle later.
REQ-022 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE.
REQ-023 The flag outputs SHALL be computed as follows:
- carry = final carry flop.
- zero = (result == 0).
- negative = result MSB.
- overflow = (a_msb == b'_msb) & (result_msb != a_msb), using latched, possibly inverted, b.
REQ-024 Flags SHALL be updated only on the RUN->DONE transition.
REQ-025 The arithmetic SHALL be exact modulo 2^WIDTH with no saturation.

Reset
REQ-026 Asserting rst_n low SHALL force IDLE asynchronously at any time, including mid-RUN or in DONE, abandoning any operation.
REQ-027 While rst_n is low, the block SHALL hold these values: in_ready=1, out_valid=0, result=0, carry=0, zero=0, negative=0, overflow=0, counter=0.
REQ-028 The first transfer SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-029 A shared CPU package SHALL hold the following:
- The WIDTH default constant, 18.
- The op encodings ADD=0 and SUB=1.
- The state enumeration IDLE/RUN/DONE.
REQ-030 The per-bit cell SHALL be one instance of the existing full_adder sub-module (ports a, b, c_in, s, c_out); no other sub-modules.
REQ-031 The counter width SHALL be clog2(WIDTH+1).

Verification
REQ-032 Add: a=5, b=3, op=0 -> result=8, carry=0, zero=0, negative=0, overflow=0, with out_valid exactly 18 cycles after transfer.
REQ-033 Subtract to zero: a=7, b=7, op=1 -> result=0, zero=1, carry=1 (no borrow), overflow=0.
REQ-034 Borrow: a=0, b=1, op=1 -> result=0x3FFFF, carry=0, negative=1, overflow=0.
REQ-035 Signed overflow cases:
- a=0x1FFFF, b=0x3FFFF, op=1 -> result=0x20000, overflow=1, negative=1.
- a=0x1FFFF, b=1, op=0 -> result=0x20000, overflow=1.
REQ-036 Backpressure: out_ready held 0 for 10 cycles in DONE -> result stable, in_ready=0, a new in_valid is ignored; out_ready=1 -> IDLE next edge.
REQ-037 Reset mid-RUN: rst_n pulsed low at cycle 9 of RUN -> immediate IDLE and zeroed outputs; next op a=2, b=2, op=0 -> result=4.
